// File: rtl/sb_packet_framing_if.sv
// Sideband framing bus: header/payload capture inputs, serializer pacing and framed phase outputs.
// The DUT connects through the slave modport. The source/sink side uses the master modport.
interface sb_packet_framing_if;
  logic [61:0] i_header;
  logic [63:0] i_data;
  logic        i_header_valid;
  logic        i_data_valid;
  logic        i_ser_done;
  logic [63:0] o_framed_packet_phase;
  logic        o_timeout_ctr_start;
  logic        o_packet_valid;

  modport slave (
    input  i_header, i_data, i_header_valid, i_data_valid, i_ser_done,
    output o_framed_packet_phase, o_timeout_ctr_start, o_packet_valid
  );

  modport master (
    output i_header, i_data, i_header_valid, i_data_valid, i_ser_done,
    input  o_framed_packet_phase, o_timeout_ctr_start, o_packet_valid
  );
endinterface

// File: rtl/sb_packet_framing.sv
// Sideband TX framing: captures header plus optional payload, then issues a parity-tagged
// header phase and a data phase as single-cycle pulses paced by the serializer.
module sb_packet_framing (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sb_packet_framing_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t      r_state,  w_state_nxt;
  logic [61:0] r_hdr_q,  w_hdr_nxt;
  logic [63:0] r_dat_q,  w_dat_nxt;
  logic        r_has_data, w_has_data_nxt;
  logic [63:0] r_phase,  w_phase_nxt;
  logic        r_vld,    w_vld_nxt;
  logic        r_tmo,    w_tmo_nxt;

  // Header phase layout: {data parity, header parity, header}.
  function automatic logic [63:0] f_hdr_phase(input logic [61:0] hdr, input logic [63:0] dat);
    return {^dat, ^hdr, hdr};
  endfunction

  // Opcode field value 5 marks requests that arm the requester's timeout counter.
  function automatic logic f_starts_timeout(input logic [61:0] hdr);
    return (hdr[17:14] == 4'd5);
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_hdr_nxt      = r_hdr_q;
    w_dat_nxt      = r_dat_q;
    w_has_data_nxt = r_has_data;
    w_phase_nxt    = r_phase;
    w_vld_nxt      = 1'b0;
    w_tmo_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_header_valid) begin
          w_hdr_nxt      = bus.i_header;
          w_dat_nxt      = bus.i_data_valid ? bus.i_data : 64'd0;
          // A zero payload is sent as a header-only packet.
          w_has_data_nxt = bus.i_data_valid && (bus.i_data != 64'd0);
          w_state_nxt    = S_HDR;
        end
      end
      S_HDR: begin
        if (bus.i_ser_done) begin
          w_vld_nxt   = 1'b1;
          w_phase_nxt = f_hdr_phase(r_hdr_q, r_dat_q);
          w_tmo_nxt   = f_starts_timeout(r_hdr_q);
          w_state_nxt = r_has_data ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.i_ser_done) begin
          w_vld_nxt   = 1'b1;
          w_phase_nxt = r_dat_q;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_hdr_q    <= '0;
      r_dat_q    <= '0;
      r_has_data <= 1'b0;
      r_phase    <= '0;
      r_vld      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hdr_q    <= w_hdr_nxt;
      r_dat_q    <= w_dat_nxt;
      r_has_data <= w_has_data_nxt;
      r_phase    <= w_phase_nxt;
      r_vld      <= w_vld_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  assign bus.o_framed_packet_phase = r_phase;
  assign bus.o_timeout_ctr_start   = r_tmo;
  assign bus.o_packet_valid        = r_vld;

endmodule

// File: tb/tb_sb_packet_framing.sv
// Scoreboard bench for sb_packet_framing: expected phases are queued at stimulus time
// and compared whenever the DUT pulses o_packet_valid.
module tb_sb_packet_framing;

  typedef struct {
    logic [63:0] phase;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  sb_packet_framing_if bus_if ();

  sb_packet_framing u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the phases a packet should produce, then pulse it into the DUT.
  task automatic send_pkt(input logic [61:0] hdr, input logic [63:0] dat, input logic dv);
    exp_t        e;
    logic [63:0] d;
    d = dv ? dat : 64'd0;
    e.phase = {^d, ^hdr, hdr};
    e.tmo   = (hdr[17:14] == 4'd5);
    sb_q.push_back(e);
    if (dv && dat != 64'd0) begin
      e.phase = dat;
      e.tmo   = 1'b0;
      sb_q.push_back(e);
    end
    bus_if.i_header       = hdr;
    bus_if.i_data         = dat;
    bus_if.i_header_valid = 1'b1;
    bus_if.i_data_valid   = dv;
    @(negedge clk);
    bus_if.i_header_valid = 1'b0;
    bus_if.i_data_valid   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [61:0] rand_hdr(input logic [3:0] op);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[17:14] = op;
    return r[61:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_if.o_packet_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexp_vld", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_phase", bus_if.o_framed_packet_phase, e.phase);
        chk("sb_tmo", 64'(bus_if.o_timeout_ctr_start), 64'(e.tmo));
      end
    end
  end

  initial begin
    logic [61:0] h;
    logic [63:0] d;
    bus_if.i_header       = '0;
    bus_if.i_data         = '0;
    bus_if.i_header_valid = 1'b0;
    bus_if.i_data_valid   = 1'b0;
    bus_if.i_ser_done     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_phase", bus_if.o_framed_packet_phase, 64'd0);
    chk("rst_vld", 64'(bus_if.o_packet_valid), 64'd0);
    chk("rst_tmo", 64'(bus_if.o_timeout_ctr_start), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Data packet, timeout opcode, serializer always ready
    h = rand_hdr(4'd5);
    d = 64'h0123_4567_89AB_CDEF;
    send_pkt(h, d, 1'b1);
    chk("t1_cap_vld", 64'(bus_if.o_packet_valid), 64'd0);
    @(negedge clk);
    chk("t1_hdr_vld", 64'(bus_if.o_packet_valid), 64'd1);
    chk("t1_hdr_tmo", 64'(bus_if.o_timeout_ctr_start), 64'd1);
    chk("t1_hdr_phase", bus_if.o_framed_packet_phase, {^d, ^h, h});
    @(negedge clk);
    chk("t1_dat_vld", 64'(bus_if.o_packet_valid), 64'd1);
    chk("t1_dat_tmo", 64'(bus_if.o_timeout_ctr_start), 64'd0);
    chk("t1_dat_phase", bus_if.o_framed_packet_phase, d);
    @(negedge clk);
    chk("t1_end_vld", 64'(bus_if.o_packet_valid), 64'd0);
    chk("t1_hold_phase", bus_if.o_framed_packet_phase, d);
    wait_drain(20);

    // Non-timeout opcode
    h = rand_hdr(4'd3);
    send_pkt(h, d, 1'b1);
    @(negedge clk);
    chk("t2_hdr_vld", 64'(bus_if.o_packet_valid), 64'd1);
    chk("t2_hdr_tmo", 64'(bus_if.o_timeout_ctr_start), 64'd0);
    wait_drain(20);

    // Serializer stall on both phases
    bus_if.i_ser_done = 1'b0;
    send_pkt(rand_hdr(4'd5), 64'hDEAD_BEEF_0000_0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_hdr_vld", 64'(bus_if.o_packet_valid), 64'd0);
      @(negedge clk);
    end
    bus_if.i_ser_done = 1'b1;
    @(negedge clk);
    chk("t3_hdr_vld", 64'(bus_if.o_packet_valid), 64'd1);
    bus_if.i_ser_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_dat_vld", 64'(bus_if.o_packet_valid), 64'd0);
    end
    bus_if.i_ser_done = 1'b1;
    @(negedge clk);
    chk("t3_dat_vld", 64'(bus_if.o_packet_valid), 64'd1);
    chk("t3_dat_phase", bus_if.o_framed_packet_phase, 64'hDEAD_BEEF_0000_0001);
    wait_drain(20);

    // Header-only via zero payload
    h = rand_hdr(4'd7);
    send_pkt(h, 64'd0, 1'b1);
    @(negedge clk);
    chk("t4_hdr_vld", 64'(bus_if.o_packet_valid), 64'd1);
    chk("t4_bit63", 64'(bus_if.o_framed_packet_phase[63]), 64'd0);
    @(negedge clk);
    chk("t4_end_vld", 64'(bus_if.o_packet_valid), 64'd0);
    repeat (4) @(negedge clk);
    wait_drain(20);

    // Second header_valid while busy in HDR is dropped
    bus_if.i_ser_done = 1'b0;
    send_pkt(rand_hdr(4'd2), 64'h1111_2222_3333_4444, 1'b1);
    bus_if.i_header       = rand_hdr(4'd5);
    bus_if.i_data         = 64'hFFFF_0000_FFFF_0000;
    bus_if.i_header_valid = 1'b1;
    bus_if.i_data_valid   = 1'b1;
    @(negedge clk);
    bus_if.i_header_valid = 1'b0;
    bus_if.i_data_valid   = 1'b0;
    @(negedge clk);
    bus_if.i_ser_done = 1'b1;
    wait_drain(20);
    repeat (4) @(negedge clk);

    // Reset asserted while in DATA aborts the packet
    send_pkt(rand_hdr(4'd5), 64'hCAFE_F00D_1234_5678, 1'b1);
    @(negedge clk);
    chk("t6_hdr_vld", 64'(bus_if.o_packet_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_phase", bus_if.o_framed_packet_phase, 64'd0);
    chk("t6_rst_vld", 64'(bus_if.o_packet_valid), 64'd0);
    chk("t6_rst_tmo", 64'(bus_if.o_timeout_ctr_start), 64'd0);
    sb_q.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_pkt(rand_hdr(4'd1), 64'hA5A5_A5A5_5A5A_5A5A, 1'b1);
    wait_drain(20);

    // Random packets with random serializer pacing
    for (int p = 0; p < 10; p++) begin
      h = rand_hdr(4'($urandom_range(3, 6)));
      d = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      bus_if.i_ser_done = 1'($urandom_range(0, 1));
      send_pkt(h, d, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
        bus_if.i_ser_done = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus_if.i_ser_done = 1'b1;
      wait_drain(20);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
